wakeup_arbiter: RTL and testbench

Shares the single wakeup broadcast bus (wakeup_active/wakeup_tag/wakeup_value into Rename and the reservation station) between NUM_FUS functional units.
- Each FU pushes completed results into its own small holding FIFO.
- A round-robin scheduler picks at most one FIFO head per cycle and drives it onto a registered broadcast bus.
- Results targeting tag 0 (rd = x0) are absorbed and never broadcast.

---
 rtl/wakeup_arbiter_pkg.sv | 12 +
 rtl/wakeup_fifo.sv | 81 ++++++++
 rtl/wakeup_arbiter.sv | 139 +++++++++++++
 tb/tb_wakeup_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wakeup_arbiter_pkg.sv
// Shared wakeup-bus widths and constants.
// Also used by Rename and the reservation station.
package wakeup_arbiter_pkg;

  localparam int TAG_WIDTH   = 6;
  localparam int VALUE_WIDTH = 32;
  localparam int SRC_WIDTH   = 3;

  // rd = x0 maps to physical tag 0: nothing to wake up
  localparam logic [TAG_WIDTH-1:0] TAG_NONE = '0;

endpackage

// File: rtl/wakeup_fifo.sv
// Per-FU holding FIFO for completed results.
// Accepts tag-0 results without storing them.
module wakeup_fifo
  import wakeup_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push_i,
  input  logic [TAG_WIDTH-1:0]            tag_i,
  input  logic [VALUE_WIDTH-1:0]          value_i,
  input  logic                            pop_i,
  output logic [TAG_WIDTH-1:0]            head_tag_o,
  output logic [VALUE_WIDTH-1:0]          head_value_o,
  output logic [$clog2(DEPTH+1)-1:0]      count_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [DEPTH-1:0]                held_vld_o,
  output logic [DEPTH-1:0][TAG_WIDTH-1:0] held_tag_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [TAG_WIDTH-1:0]   tag_q [DEPTH];
  logic [VALUE_WIDTH-1:0] val_q [DEPTH];
  logic [PW-1:0]          rd_q, rd_d;
  logic [PW-1:0]          wr_q, wr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   wr_en, rd_en;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  // Full refuses input even if popped this cycle
  assign wr_en = push_i && !full_o
              && (tag_i != TAG_NONE);
  assign rd_en = pop_i && !empty_o;

  assign rd_d  = rd_q + PW'(rd_en);
  assign wr_d  = wr_q + PW'(wr_en);
  assign cnt_d = cnt_q + CW'(wr_en)
               - CW'(rd_en);

  assign head_tag_o   = tag_q[rd_q];
  assign head_value_o = val_q[rd_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_q] <= tag_i;
      val_q[wr_q] <= value_i;
    end
  end

  always_comb begin
    logic [PW-1:0] off;
    off        = '0;
    held_vld_o = '0;
    held_tag_o = '0;
    for (int j = 0; j < DEPTH; j++) begin
      off           = PW'(j) - rd_q;
      held_vld_o[j] = (CW'(off) < cnt_q);
      held_tag_o[j] = tag_q[j];
    end
  end

endmodule

// File: rtl/wakeup_arbiter.sv
// Round-robin arbiter sharing the wakeup bus
// among NUM_FUS functional units.
module wakeup_arbiter
  import wakeup_arbiter_pkg::*;
#(
  parameter int NUM_FUS    = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_FUS-1:0]             fu_valid,
  input  logic [TAG_WIDTH*NUM_FUS-1:0]   fu_tag,
  input  logic [VALUE_WIDTH*NUM_FUS-1:0] fu_value,
  output logic [NUM_FUS-1:0]             fu_ready,
  output logic                           wakeup_active,
  output logic [TAG_WIDTH-1:0]           wakeup_tag,
  output logic [VALUE_WIDTH-1:0]         wakeup_value,
  output logic [SRC_WIDTH-1:0]           wakeup_source,
  output logic [$clog2(NUM_FUS*FIFO_DEPTH+1)-1:0] pending_count
);

  localparam int IW  = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH+1);
  localparam int PCW = $clog2(NUM_FUS*FIFO_DEPTH+1);

  logic [TAG_WIDTH-1:0]   hd_tag [NUM_FUS];
  logic [VALUE_WIDTH-1:0] hd_val [NUM_FUS];
  logic [CW-1:0]          cnt    [NUM_FUS];
  logic [NUM_FUS-1:0]     full, empty, pop;

  logic [FIFO_DEPTH-1:0]                held_vld [NUM_FUS];
  logic [FIFO_DEPTH-1:0][TAG_WIDTH-1:0] held_tag [NUM_FUS];

  logic [IW-1:0]          rr_q, rr_d;
  logic                   act_q;
  logic [TAG_WIDTH-1:0]   tag_q, sel_tag;
  logic [VALUE_WIDTH-1:0] val_q, sel_val;
  logic [SRC_WIDTH-1:0]   src_q;
  logic                   gnt_vld;
  logic [IW-1:0]          gnt_idx;
  logic [PCW-1:0]         pend;

  for (genvar i = 0; i < NUM_FUS; i++) begin : g_fu
    wakeup_fifo #(
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (fu_valid[i]),
      .tag_i       (fu_tag[TAG_WIDTH*i +: TAG_WIDTH]),
      .value_i     (fu_value[VALUE_WIDTH*i +: VALUE_WIDTH]),
      .pop_i       (pop[i]),
      .head_tag_o  (hd_tag[i]),
      .head_value_o(hd_val[i]),
      .count_o     (cnt[i]),
      .full_o      (full[i]),
      .empty_o     (empty[i]),
      .held_vld_o  (held_vld[i]),
      .held_tag_o  (held_tag[i])
    );
    assign pop[i] = gnt_vld && (gnt_idx == IW'(i));
  end

  assign fu_ready = ~full;

  // Scan from rr_q upward; descending loop lets the nearest win
  always_comb begin
    int t;
    t       = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_FUS - 1; k >= 0; k--) begin
      t = int'(rr_q) + k;
      if (t >= NUM_FUS) t = t - NUM_FUS;
      if (!empty[t]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(t);
      end
    end
  end

  always_comb begin
    sel_tag = '0;
    sel_val = '0;
    pend    = '0;
    for (int i = 0; i < NUM_FUS; i++) begin
      if (pop[i]) begin
        sel_tag = hd_tag[i];
        sel_val = hd_val[i];
      end
      pend = pend + PCW'(cnt[i]);
    end
  end

  assign rr_d = (gnt_idx == IW'(NUM_FUS - 1))
              ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q  <= '0;
      act_q <= 1'b0;
      tag_q <= '0;
      val_q <= '0;
      src_q <= '0;
    end else begin
      act_q <= gnt_vld;
      if (gnt_vld) begin
        rr_q  <= rr_d;
        tag_q <= sel_tag;
        val_q <= sel_val;
        src_q <= SRC_WIDTH'(gnt_idx);
      end
    end
  end

  assign wakeup_active = act_q;
  assign wakeup_tag    = tag_q;
  assign wakeup_value  = val_q;
  assign wakeup_source = src_q;
  assign pending_count = pend;

  // A tag waiting twice means Rename handed out a live tag
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int a = 0; a < NUM_FUS*FIFO_DEPTH; a++) begin
        for (int b = a + 1; b < NUM_FUS*FIFO_DEPTH; b++) begin
          if (held_vld[a/FIFO_DEPTH][a%FIFO_DEPTH]
              && held_vld[b/FIFO_DEPTH][b%FIFO_DEPTH]
              && held_tag[a/FIFO_DEPTH][a%FIFO_DEPTH] != TAG_NONE
              && held_tag[a/FIFO_DEPTH][a%FIFO_DEPTH]
                 == held_tag[b/FIFO_DEPTH][b%FIFO_DEPTH])
            $fatal(1, "duplicate wakeup tag %0h",
                   held_tag[a/FIFO_DEPTH][a%FIFO_DEPTH]);
        end
      end
    end
  end

endmodule

// File: tb/tb_wakeup_arbiter.sv
// Scoreboard bench for wakeup_arbiter: directed
// scenarios plus random traffic against a queue model.
module tb_wakeup_arbiter;

  localparam int N = 3;
  localparam int D = 2;

  typedef struct packed {
    logic [5:0]  tag;
    logic [31:0] val;
  } ent_t;

  typedef struct packed {
    logic [5:0]  tag;
    logic [31:0] val;
    logic [2:0]  src;
  } exp_t;

  logic          clk = 0;
  logic          reset = 1;
  logic [N-1:0]  fu_valid = '0;
  logic [6*N-1:0]  fu_tag = '0;
  logic [32*N-1:0] fu_value = '0;
  logic [N-1:0]  fu_ready;
  logic          wakeup_active;
  logic [5:0]    wakeup_tag;
  logic [31:0]   wakeup_value;
  logic [2:0]    wakeup_source;
  logic [2:0]    pending_count;

  wakeup_arbiter #(
    .NUM_FUS(N),
    .FIFO_DEPTH(D)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fu_valid     (fu_valid),
    .fu_tag       (fu_tag),
    .fu_value     (fu_value),
    .fu_ready     (fu_ready),
    .wakeup_active(wakeup_active),
    .wakeup_tag   (wakeup_tag),
    .wakeup_value (wakeup_value),
    .wakeup_source(wakeup_source),
    .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  ent_t mq [N][$];
  exp_t exp_q [$];
  int   src_log [$];
  int   m_rr = 0;
  logic m_active = 0;
  logic [5:0]  m_tag = '0;
  logic [31:0] m_val = '0;
  logic [2:0]  m_src = '0;
  logic [5:0]  next_tag = 6'd0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  function automatic logic busy();
    logic b;
    b = m_active;
    for (int i = 0; i < N; i++)
      if (mq[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  function automatic logic [5:0] alloc();
    next_tag = (next_tag == 6'd63) ? 6'd1 : next_tag + 6'd1;
    return next_tag;
  endfunction

  task automatic check_outputs();
    logic [N-1:0] er;
    int tot;
    tot = 0;
    for (int i = 0; i < N; i++) begin
      er[i] = (mq[i].size() < D);
      tot += mq[i].size();
    end
    chk("ready", fu_ready, er);
    chk("pending", pending_count, tot);
    chk("active", wakeup_active, m_active);
    chk("bus_tag", wakeup_tag, m_tag);
    chk("bus_value", wakeup_value, m_val);
    chk("bus_source", wakeup_source, m_src);
  endtask

  // Called at a negedge; returns at the next negedge
  task automatic step(input logic [N-1:0] v,
                      input logic [6*N-1:0] t,
                      input logic [32*N-1:0] d,
                      output logic [N-1:0] acc);
    int g;
    ent_t e;
    check_outputs();
    for (int i = 0; i < N; i++)
      acc[i] = v[i] && (mq[i].size() < D);
    fu_valid = v;
    fu_tag   = t;
    fu_value = d;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_rr + k) % N;
      if (g < 0 && mq[idx].size() > 0) g = idx;
    end
    if (g >= 0) begin
      e = mq[g].pop_front();
      exp_q.push_back('{e.tag, e.val, 3'(g)});
      m_rr = (g + 1) % N;
      m_active = 1'b1;
      m_tag = e.tag;
      m_val = e.val;
      m_src = 3'(g);
    end else begin
      m_active = 1'b0;
    end
    for (int i = 0; i < N; i++)
      if (acc[i] && t[6*i +: 6] != 6'd0)
        mq[i].push_back('{t[6*i +: 6], d[32*i +: 32]});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    logic [N-1:0] a;
    step('0, '0, '0, a);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fu_valid = '0;
    #1;
    chk("rst_active", wakeup_active, 0);
    chk("rst_tag", wakeup_tag, 0);
    chk("rst_value", wakeup_value, 0);
    chk("rst_source", wakeup_source, 0);
    chk("rst_pending", pending_count, 0);
    for (int i = 0; i < N; i++) mq[i].delete();
    exp_q.delete();
    m_rr = 0;
    m_active = 0;
    m_tag = '0;
    m_val = '0;
    m_src = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && busy(); k++) idle();
    chk("drain_done", busy(), 0);
  endtask

  // Monitor: pops one expectation per broadcast seen
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && wakeup_active) begin
        src_log.push_back(int'(wakeup_source));
        if (exp_q.size() == 0) begin
          chk("unexpected_bcast", wakeup_tag, 0);
          if (wakeup_tag == 0) chk("unexpected_bcast", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_tag", wakeup_tag, e.tag);
          chk("sb_value", wakeup_value, e.val);
          chk("sb_source", wakeup_source, e.src);
        end
      end
    end
  end

  initial begin
    logic [N-1:0]    acc;
    logic [6*N-1:0]  t;
    logic [32*N-1:0] d;
    logic [N-1:0]    hv;
    logic [5:0]      ht [N];
    logic [31:0]     hd [N];
    int k2, f0, third_at;

    repeat (2) @(negedge clk);
    chk("init_active", wakeup_active, 0);
    chk("init_pending", pending_count, 0);
    chk("init_tag", wakeup_tag, 0);
    reset = 1'b0;

    // single result from FU1
    t = '0; d = '0;
    t[6 +: 6] = 6'h21;
    d[32 +: 32] = 32'hDEADBEEF;
    step(3'b010, t, d, acc);
    idle();
    chk("t1_active", wakeup_active, 1);
    chk("t1_tag", wakeup_tag, 6'h21);
    chk("t1_value", wakeup_value, 32'hDEADBEEF);
    chk("t1_source", wakeup_source, 1);
    idle();
    chk("t1_low", wakeup_active, 0);

    // tag 0 is absorbed
    t = '0; d = '0;
    d[0 +: 32] = 32'd5;
    step(3'b001, t, d, acc);
    chk("t2_pending", pending_count, 0);
    chk("t2_ready", fu_ready, 3'b111);
    idle();
    chk("t2_active", wakeup_active, 0);
    idle();

    // round-robin fairness
    do_reset();
    src_log.delete();
    t = {6'h03, 6'h02, 6'h01};
    d = {32'h33, 32'h22, 32'h11};
    step(3'b111, t, d, acc);
    t = {6'h06, 6'h05, 6'h04};
    d = {32'h66, 32'h55, 32'h44};
    step(3'b111, t, d, acc);
    drain();
    chk("t3_count", src_log.size(), 6);
    for (int i = 0; i < 6 && i < src_log.size(); i++)
      chk("t3_order", src_log[i], i % 3);

    // full FIFO on FU2 while FU0 floods
    do_reset();
    k2 = 0; f0 = 0; third_at = -1;
    for (int s = 0; s < 12 && k2 < 3; s++) begin
      t = '0; d = '0;
      t[12 +: 6] = 6'(8'h31 + k2);
      d[64 +: 32] = 32'hC000 + k2;
      t[0 +: 6] = 6'(8'h10 + f0);
      d[0 +: 32] = 32'hA000 + f0;
      step(3'b101, t, d, acc);
      if (acc[0]) f0++;
      if (acc[2]) begin
        k2++;
        if (k2 == 3) third_at = s;
      end
      if (s == 1) chk("t4_full", fu_ready[2], 0);
    end
    chk("t4_third_at", third_at, 3);
    drain();

    // mid-operation reset
    do_reset();
    t = {6'h03, 6'h02, 6'h01};
    d = {32'h3, 32'h2, 32'h1};
    step(3'b111, t, d, acc);
    t = '0; t[0 +: 6] = 6'h04; d = '0;
    step(3'b001, t, d, acc);
    do_reset();
    chk("t5_ready", fu_ready, 3'b111);
    repeat (4) idle();

    // enqueue and dequeue on the same FIFO
    do_reset();
    t = '0; t[0 +: 6] = 6'h2A; d = '0; d[0 +: 32] = 32'hAA;
    step(3'b001, t, d, acc);
    t = '0; t[0 +: 6] = 6'h2B; d = '0; d[0 +: 32] = 32'hBB;
    step(3'b001, t, d, acc);
    chk("t6_count", pending_count, 1);
    idle();
    chk("t6_tag", wakeup_tag, 6'h2B);
    chk("t6_active", wakeup_active, 1);
    drain();

    // random traffic
    do_reset();
    next_tag = 6'd0;
    hv = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      for (int i = 0; i < N; i++) begin
        if (!hv[i] && $urandom_range(0, 9) < 4) begin
          hv[i] = 1'b1;
          ht[i] = ($urandom_range(0, 7) == 0) ? 6'd0 : alloc();
          hd[i] = $urandom;
        end
      end
      for (int i = 0; i < N; i++) begin
        t[6*i +: 6]   = hv[i] ? ht[i] : 6'd0;
        d[32*i +: 32] = hv[i] ? hd[i] : 32'd0;
      end
      step(hv, t, d, acc);
      hv = hv & ~acc;
    end
    drain();
    chk("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
